// File: rtl/bus_cmd_master.sv
// Single-outstanding bus master: takes one command at a time, issues a single-cycle strobe,
// waits for ack (or times out), then presents the result on a valid/ready response port.
module bus_cmd_master #(
  parameter int DATAW      = 8,
  parameter int TMO_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [7:0]       i_cmd_addr,
  input  logic [DATAW-1:0] i_cmd_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [DATAW-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_stb,
  output logic             o_we,
  output logic [7:0]       o_addr,
  output logic [DATAW-1:0] o_data,
  input  logic             i_ack,
  input  logic [DATAW-1:0] i_data,
  output logic [7:0]       o_tmo_cnt
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic [7:0]       tmo_cnt_q;
  logic [7:0]       tmo_cnt_d;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [DATAW-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             stb_q;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [DATAW-1:0] data_q;

  assign timer_d   = timer_q + 1'b1;
  assign tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;

  // All outputs are registered; cmd_ready is a state flag so it never follows cmd_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tmo_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (i_cmd_valid && cmd_ready_q) begin
            we_q        <= i_cmd_we;
            addr_q      <= i_cmd_addr;
            data_q      <= i_cmd_data;
            cmd_ready_q <= 1'b0;
            stb_q       <= 1'b1;
            state_q     <= S_STROBE;
          end
        end

        S_STROBE: begin
          stb_q   <= 1'b0;
          timer_q <= '0;
          state_q <= S_WAIT;
        end

        // An ack on the expiry cycle takes priority over the timeout.
        S_WAIT: begin
          if (i_ack) begin
            rsp_data_q  <= we_q ? '0 : i_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timer_q == TIMER_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_stb       = stb_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_data      = data_q;
  assign o_tmo_cnt   = tmo_cnt_q;

endmodule
